// File: rtl/inv_sub_add_key.sv
// rtl/inv_sub_add_key.sv - AES decryption feeder: InvShiftRows, InvSubBytes, AddRoundKey (fast mode: INV_SAK_FAST_EN)

// Combinational AES inverse S-box: inverse affine map followed by GF(2^8) inversion.
module inv_sbox (
    input  logic [7:0] i_byte,
    output logic [7:0] o_byte
);
    // Product in GF(2^8) modulo x^8 + x^4 + x^3 + x + 1.
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // Multiplicative inverse as a^254; maps 0 to 0 as AES requires.
    function automatic logic [7:0] gf_inv(input logic [7:0] a);
        logic [7:0] sq;
        logic [7:0] r;
        sq = a;
        r  = 8'h01;
        for (int k = 1; k < 8; k++) begin
            sq = gf_mul(sq, sq);
            r  = gf_mul(r, sq);
        end
        return r;
    endfunction

    logic [7:0] w_aff;

    // Undo the forward affine transform, then invert in the field.
    always_comb begin
        w_aff  = {i_byte[6:0], i_byte[7]} ^ {i_byte[4:0], i_byte[7:5]} ^
                 {i_byte[1:0], i_byte[7:2]} ^ 8'h05;
        o_byte = gf_inv(w_aff);
    end
endmodule

module inv_sub_add_key (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_state,
    input  logic [127:0] in_key,
    input  logic         in_last,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_state,
    output logic         out_last
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t       r_state;
    state_t       w_next;
    logic [1:0]   r_col;
    logic [127:0] r_sh;
    logic [127:0] r_key;
    logic [127:0] r_out;
    logic         r_last;
    logic [127:0] w_shift;
    logic         w_capture;
    logic         w_in_ready;

    // InvShiftRows is pure wiring: dst(r,c) = src(r,(c-r) mod 4), byte k = 4c+r at bits [127-8k -: 8].
    always_comb begin
        w_shift = 128'h0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                w_shift[127 - 8*(4*c + r) -: 8] = in_state[127 - 8*(4*((c - r) & 3) + r) -: 8];
            end
        end
    end

`ifdef INV_SAK_FAST_EN
    logic [127:0] w_sb;
    logic [127:0] w_full;

    for (genvar g = 0; g < 16; g++) begin : g_sbox
        inv_sbox u_sbox (
            .i_byte (r_sh[127 - 8*g -: 8]),
            .o_byte (w_sb[127 - 8*g -: 8])
        );
    end

    // Whole state substituted and keyed in one cycle.
    always_comb begin
        w_full = w_sb ^ r_key;
    end
`else
    logic [31:0] w_col_in;
    logic [31:0] w_key_col;
    logic [31:0] w_sb;
    logic [31:0] w_col_out;

    // Select the column currently being processed from the captured state and key.
    always_comb begin
        w_col_in  = r_sh[127:96];
        w_key_col = r_key[127:96];
        case (r_col)
            2'd0: begin w_col_in = r_sh[127:96]; w_key_col = r_key[127:96]; end
            2'd1: begin w_col_in = r_sh[95:64];  w_key_col = r_key[95:64];  end
            2'd2: begin w_col_in = r_sh[63:32];  w_key_col = r_key[63:32];  end
            default: begin w_col_in = r_sh[31:0]; w_key_col = r_key[31:0]; end
        endcase
        w_col_out = w_sb ^ w_key_col;
    end

    for (genvar g = 0; g < 4; g++) begin : g_sbox
        inv_sbox u_sbox (
            .i_byte (w_col_in[31 - 8*g -: 8]),
            .o_byte (w_sb[31 - 8*g -: 8])
        );
    end
`endif

    // Next-state and handshake decode.
    always_comb begin
        w_next     = r_state;
        w_capture  = 1'b0;
        w_in_ready = 1'b0;
        case (r_state)
            IDLE: begin
                w_in_ready = 1'b1;
                if (in_valid) begin
                    w_capture = 1'b1;
                    w_next    = RUN;
                end
            end
            RUN: begin
`ifdef INV_SAK_FAST_EN
                w_next = DONE;
`else
                if (r_col == 2'd3) w_next = DONE;
`endif
            end
            DONE: begin
`ifdef INV_SAK_FAST_EN
                w_in_ready = out_ready;
                if (out_ready) begin
                    if (in_valid) begin
                        w_capture = 1'b1;
                        w_next    = RUN;
                    end else begin
                        w_next = IDLE;
                    end
                end
`else
                if (out_ready) w_next = IDLE;
`endif
            end
            default: w_next = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next;
    end

    // Capture registers and output column writes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_col  <= 2'd0;
            r_sh   <= 128'h0;
            r_key  <= 128'h0;
            r_out  <= 128'h0;
            r_last <= 1'b0;
        end else if (w_capture) begin
            r_sh   <= w_shift;
            r_key  <= in_key;
            r_last <= in_last;
            r_col  <= 2'd0;
        end else if (r_state == RUN) begin
`ifdef INV_SAK_FAST_EN
            r_out <= w_full;
`else
            case (r_col)
                2'd0:    r_out[127:96] <= w_col_out;
                2'd1:    r_out[95:64]  <= w_col_out;
                2'd2:    r_out[63:32]  <= w_col_out;
                default: r_out[31:0]   <= w_col_out;
            endcase
            r_col <= r_col + 2'd1;
`endif
        end
    end

    assign in_ready  = w_in_ready;
    assign out_valid = (r_state == DONE);
    assign out_state = r_out;
    assign out_last  = r_last;
endmodule

// File: tb/tb_inv_sub_add_key.sv
// tb/tb_inv_sub_add_key.sv - randomized self-checking bench for inv_sub_add_key
module tb_inv_sub_add_key;
    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [127:0] in_state = '0;
    logic [127:0] in_key = '0;
    logic         in_last = 1'b0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [127:0] out_state;
    logic         out_last;

    int n_checks = 0;
    int n_fail   = 0;
    logic [7:0] inv_tab [256];

`ifdef INV_SAK_FAST_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 5;
`endif

    inv_sub_add_key dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_state(in_state), .in_key(in_key), .in_last(in_last),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_state(out_state), .out_last(out_last)
    );

    always #5 clk = ~clk;

    // Carry-less product then reduction by 0x11b.
    function automatic logic [7:0] ref_mul(input logic [7:0] a, input logic [7:0] b);
        logic [14:0] p;
        p = '0;
        for (int i = 0; i < 8; i++) if (b[i]) p = p ^ (15'(a) << i);
        for (int i = 14; i >= 8; i--) if (p[i]) p = p ^ (15'h11b << (i - 8));
        return p[7:0];
    endfunction

    function automatic logic [7:0] rotl(input logic [7:0] x, input int n);
        logic [15:0] d;
        d = {x, x} << n;
        return d[15:8];
    endfunction

    // Forward S-box from its definition, inverted into a lookup table.
    function automatic void build_table();
        logic [7:0] inv, s;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++) if (ref_mul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            s = inv ^ rotl(inv, 1) ^ rotl(inv, 2) ^ rotl(inv, 3) ^ rotl(inv, 4) ^ 8'h63;
            inv_tab[s] = 8'(x);
        end
    endfunction

    function automatic logic [7:0] get_byte(input logic [127:0] v, input int k);
        logic [127:0] t;
        t = v >> (120 - 8*k);
        return t[7:0];
    endfunction

    function automatic logic [127:0] model(input logic [127:0] st, input logic [127:0] key);
        logic [127:0] res;
        res = '0;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                res = (res << 8) | 128'(inv_tab[get_byte(st, 4*((c - r + 4) % 4) + r)] ^ get_byte(key, 4*c + r));
        return res;
    endfunction

    task automatic send(input logic [127:0] st, input logic [127:0] key, input logic lst);
        int w;
        w = 0;
        while (!in_ready && w < 20) begin @(posedge clk); #1; w++; end
        n_checks++;
        if (in_ready !== 1'b1) begin n_fail++; $display("FAIL send_ready: in_ready=%b required 1", in_ready); end
        in_valid = 1'b1; in_state = st; in_key = key; in_last = lst;
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_valid(output int lat);
        lat = 1;
        while (!out_valid && lat < 30) begin @(posedge clk); #1; lat++; end
    endtask

    task automatic run_block(input logic [127:0] st, input logic [127:0] key, input logic lst,
                             input logic [127:0] exp, input string name);
        int lat;
        send(st, key, lst);
        wait_valid(lat);
        n_checks++;
        if (lat != LAT) begin n_fail++; $display("FAIL %s_latency: got %0d edges required %0d", name, lat, LAT); end
        n_checks++;
        if (out_state !== exp) begin n_fail++; $display("FAIL %s_state: got %h required %h", name, out_state, exp); end
        n_checks++;
        if (out_last !== lst) begin n_fail++; $display("FAIL %s_last: got %b required %b", name, out_last, lst); end
        repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        n_checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            n_fail++; $display("FAIL %s_handoff: out_valid=%b in_ready=%b required 0/1", name, out_valid, in_ready);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_state !== 128'h0 || out_last !== 1'b0) begin
            n_fail++; $display("FAIL reset: ov=%b ir=%b os=%h ol=%b required 0 1 0 0", out_valid, in_ready, out_state, out_last);
        end
        rst = 1'b0;
    endtask

    task automatic test_zero();
        run_block(128'h0, 128'h0, 1'b0, {16{8'h52}}, "zero");
    endtask

    task automatic test_key_xor();
        run_block(128'h0, {128{1'b1}}, 1'b0, {16{8'had}}, "key_xor");
    endtask

    task automatic test_fips();
        run_block(128'h7ad5fda789ef4e272bca100b3d9ff59f, 128'h549932d1f08557681093ed9cbe2c974e, 1'b0,
                  128'he9f74eec023020f61bf2ccf2353c21c7, "fips_c1");
    endtask

    task automatic test_random();
        logic [127:0] st, key;
        for (int i = 0; i < 8; i++) begin
            st  = {$urandom, $urandom, $urandom, $urandom};
            key = {$urandom, $urandom, $urandom, $urandom};
            run_block(st, key, 1'($urandom), model(st, key), "random");
        end
    endtask

    task automatic test_backpressure();
        logic [127:0] st, key, held;
        int lat;
        st  = {$urandom, $urandom, $urandom, $urandom};
        key = {$urandom, $urandom, $urandom, $urandom};
        send(st, key, 1'b1);
        wait_valid(lat);
        held = out_state;
        n_checks++;
        if (held !== model(st, key) || out_last !== 1'b1) begin
            n_fail++; $display("FAIL bp_result: got %h/%b required %h/1", held, out_last, model(st, key));
        end
        in_valid = 1'b1; in_state = ~st; in_key = ~key; in_last = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            n_checks++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_state !== held || out_last !== 1'b1) begin
                n_fail++; $display("FAIL bp_hold: ov=%b ir=%b os=%h ol=%b required 1 0 %h 1", out_valid, in_ready, out_state, out_last, held);
            end
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            n_checks++;
            if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
                n_fail++; $display("FAIL bp_idle: ov=%b ir=%b required 0 1", out_valid, in_ready);
            end
        end
    endtask

    task automatic test_async_reset();
        int lat;
        send(128'h0, {128{1'b1}}, 1'b1);
        wait_valid(lat);
        @(negedge clk); #2;
        rst = 1'b1;
        #1;
        n_checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_state !== 128'h0 || out_last !== 1'b0) begin
            n_fail++; $display("FAIL async_reset: ov=%b ir=%b os=%h ol=%b required 0 1 0 0", out_valid, in_ready, out_state, out_last);
        end
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic test_midop_reset();
        logic [127:0] st, key;
        send({$urandom, $urandom, $urandom, $urandom}, {$urandom, $urandom, $urandom, $urandom}, 1'b1);
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        n_checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_state !== 128'h0 || out_last !== 1'b0) begin
            n_fail++; $display("FAIL midop_reset: ov=%b ir=%b os=%h ol=%b required 0 1 0 0", out_valid, in_ready, out_state, out_last);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        st  = {$urandom, $urandom, $urandom, $urandom};
        key = {$urandom, $urandom, $urandom, $urandom};
        run_block(st, key, 1'b0, model(st, key), "after_reset");
    endtask

    initial begin
        build_table();
        test_reset();
        test_zero();
        test_key_xor();
        test_fips();
        test_random();
        test_backpressure();
        test_async_reset();
        test_midop_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
